// File: rtl/sram_like_arbiter.sv
// Multi-master sram-like arbiter: fixed-priority or round-robin grant onto one
// memory port, with in-order response routing through an in-flight ID FIFO.
module sram_like_arbiter #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RR_MODE         = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          m_req,
  input  logic [NUM_PORTS-1:0]          m_wr,
  input  logic [2*NUM_PORTS-1:0]        m_size,
  input  logic [NUM_PORTS*DATA_W/8-1:0] m_wstrb,
  input  logic [NUM_PORTS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   m_wdata,
  output logic [NUM_PORTS-1:0]          m_addr_ok,
  output logic [NUM_PORTS-1:0]          m_data_ok,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_wr,
  output logic [1:0]                    s_size,
  output logic [DATA_W/8-1:0]           s_wstrb,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_addr_ok,
  input  logic                          s_data_ok,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          busy,
  output logic                          proto_err
);

  localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [0:0] {ST_FREE, ST_LOCK} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_proto_err;

  logic [IDX_W-1:0] w_grant;
  logic [IDX_W-1:0] w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_head    = r_fifo[r_rd_ptr];
  assign s_req     = !reset && ((|m_req) || (r_state == ST_LOCK)) && !w_full;
  assign w_accept  = s_req && s_addr_ok;
  assign w_pop     = !reset && s_data_ok && !w_empty;
  assign m_rdata   = s_rdata;
  assign busy      = !w_empty;
  assign proto_err = r_proto_err;

  // Grant: locked index wins; otherwise fixed priority or cyclic search from rr_ptr
  always_comb begin
    logic found;
    int   j;
    w_grant = '0;
    found   = 1'b0;
    j       = 0;
    if (RR_MODE != 0) begin
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
        j = int'(r_rr_ptr) + k;
        if (j >= int'(NUM_PORTS)) j = j - int'(NUM_PORTS);
        if (!found && m_req[j]) begin
          w_grant = IDX_W'(j);
          found   = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        if (!found && m_req[i]) begin
          w_grant = IDX_W'(i);
          found   = 1'b1;
        end
      end
    end
    if (r_state == ST_LOCK) w_grant = r_lock_idx;
  end

  // Lock held from a stalled request until the slave accepts it
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_FREE;
    end else if (s_req) begin
      w_state_nxt = ST_LOCK;
    end
  end

  always_comb begin
    s_wr      = 1'b0;
    s_size    = '0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (s_req && (w_grant == IDX_W'(i))) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_wstrb = m_wstrb[STRB_W*i +: STRB_W];
        s_addr  = m_addr[ADDR_W*i +: ADDR_W];
        s_wdata = m_wdata[DATA_W*i +: DATA_W];
      end
      m_addr_ok[i] = w_accept && (w_grant == IDX_W'(i));
      m_data_ok[i] = w_pop && (w_head == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FREE;
      r_lock_idx  <= '0;
      r_rr_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (s_req && !s_addr_ok) r_lock_idx <= w_grant;
      if (w_accept) begin
        r_rr_ptr <= (w_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s_data_ok && w_empty) r_proto_err <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read behind the write pointer
  always_ff @(posedge clk) begin
    if (!reset && w_accept) r_fifo[r_wr_ptr] <= w_grant;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a 2-port fixed-priority instance and a
// 3-port round-robin instance sharing clock and reset.
module tb_sram_like_arbiter;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  // fixed-priority instance
  logic [1:0]  f_req, f_wr, f_aok, f_dok;
  logic [3:0]  f_size;
  logic [7:0]  f_wstrb;
  logic [63:0] f_addr, f_wdata;
  logic [31:0] f_rdata, f_saddr, f_swdata, f_srdata;
  logic        f_sreq, f_swr, f_saok, f_sdok, f_busy, f_perr;
  logic [1:0]  f_ssize;
  logic [3:0]  f_sstrb;

  // round-robin instance
  logic [2:0]  r_req, r_wr, r_aok, r_dok;
  logic [5:0]  r_size;
  logic [11:0] r_wstrb;
  logic [95:0] r_addr, r_wdata;
  logic [31:0] r_rdata, r_saddr, r_swdata, r_srdata;
  logic        r_sreq, r_swr, r_saok, r_sdok, r_busy, r_perr;
  logic [1:0]  r_ssize;
  logic [3:0]  r_sstrb;

  logic [2:0]  rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  sram_like_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .RR_MODE(0)) u_fp (
    .clk(clk), .reset(reset),
    .m_req(f_req), .m_wr(f_wr), .m_size(f_size), .m_wstrb(f_wstrb), .m_addr(f_addr), .m_wdata(f_wdata),
    .m_addr_ok(f_aok), .m_data_ok(f_dok), .m_rdata(f_rdata),
    .s_req(f_sreq), .s_wr(f_swr), .s_size(f_ssize), .s_wstrb(f_sstrb), .s_addr(f_saddr), .s_wdata(f_swdata),
    .s_addr_ok(f_saok), .s_data_ok(f_sdok), .s_rdata(f_srdata),
    .busy(f_busy), .proto_err(f_perr)
  );

  sram_like_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset),
    .m_req(r_req), .m_wr(r_wr), .m_size(r_size), .m_wstrb(r_wstrb), .m_addr(r_addr), .m_wdata(r_wdata),
    .m_addr_ok(r_aok), .m_data_ok(r_dok), .m_rdata(r_rdata),
    .s_req(r_sreq), .s_wr(r_swr), .s_size(r_ssize), .s_wstrb(r_sstrb), .s_addr(r_saddr), .s_wdata(r_swdata),
    .s_addr_ok(r_saok), .s_data_ok(r_sdok), .s_rdata(r_srdata),
    .busy(r_busy), .proto_err(r_perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    f_wr = 2'b10;  f_size = 4'b1010;  f_wstrb = 8'hF0;
    f_addr  = {32'h0000_1000, 32'h1C00_0000};
    f_wdata = {32'hDEAD_BEEF, 32'h0000_0000};
    f_srdata = 32'h1C00_0000;
    r_req = '0; r_wr = '0; r_size = 6'b101010; r_wstrb = '0;
    r_addr = {32'h300, 32'h200, 32'h100}; r_wdata = '0;
    r_saok = 1'b0; r_sdok = 1'b0; r_srdata = 32'h0;

    // reset gates memory and master handshakes
    reset = 1'b1; f_req = 2'b11; f_saok = 1'b1; f_sdok = 1'b1;
    #1;
    chk("rst_sreq", 64'(f_sreq), 64'd0);
    chk("rst_aok", 64'(f_aok), 64'd0);
    chk("rst_dok", 64'(f_dok), 64'd0);
    nxt(); nxt();

    // fixed priority: port 0 wins every cycle, port 1 starves
    reset = 1'b0; f_sdok = 1'b0;
    #1;
    chk("fp_sreq", 64'(f_sreq), 64'd1);
    chk("fp_aok0", 64'(f_aok), 64'b01);
    chk("fp_saddr", 64'(f_saddr), 64'h1C00_0000);
    chk("fp_busy0", 64'(f_busy), 64'd0);
    nxt();
    f_sdok = 1'b1;
    #1;
    chk("fp_aok1", 64'(f_aok), 64'b01);
    chk("fp_dok1", 64'(f_dok), 64'b01);
    chk("fp_rdata", 64'(f_rdata), 64'h1C00_0000);
    chk("fp_busy1", 64'(f_busy), 64'd1);
    nxt();
    #1;
    chk("fp_aok2", 64'(f_aok), 64'b01);
    chk("fp_dok2", 64'(f_dok), 64'b01);
    nxt();
    f_req = 2'b00;
    #1;
    chk("fp_idle_sreq", 64'(f_sreq), 64'd0);
    chk("fp_dok3", 64'(f_dok), 64'b01);
    nxt();
    f_sdok = 1'b0;
    #1;
    chk("fp_busy_end", 64'(f_busy), 64'd0);
    chk("fp_perr0", 64'(f_perr), 64'd0);

    // lock: stalled port 1 keeps the grant although port 0 has priority
    nxt();
    f_req = 2'b10; f_saok = 1'b0;
    #1;
    chk("lk_sreq", 64'(f_sreq), 64'd1);
    chk("lk_saddr1", 64'(f_saddr), 64'h0000_1000);
    chk("lk_swr", 64'(f_swr), 64'd1);
    chk("lk_sstrb", 64'(f_sstrb), 64'hF);
    chk("lk_ssize", 64'(f_ssize), 64'd2);
    chk("lk_aok_none", 64'(f_aok), 64'd0);
    nxt();
    f_req = 2'b11;
    #1;
    chk("lk_saddr2", 64'(f_saddr), 64'h0000_1000);
    chk("lk_swdata", 64'(f_swdata), 64'hDEAD_BEEF);
    nxt();
    #1;
    chk("lk_saddr3", 64'(f_saddr), 64'h0000_1000);
    nxt();
    f_saok = 1'b1;
    #1;
    chk("lk_aok1", 64'(f_aok), 64'b10);
    chk("lk_saddr4", 64'(f_saddr), 64'h0000_1000);
    nxt();
    f_req = 2'b01;
    #1;
    chk("lk_aok0", 64'(f_aok), 64'b01);
    chk("lk_saddr0", 64'(f_saddr), 64'h1C00_0000);
    chk("lk_swr0", 64'(f_swr), 64'd0);
    nxt();

    // push and pop together at count 2; oldest (port 1) returns first
    f_sdok = 1'b1;
    #1;
    chk("pp_dok", 64'(f_dok), 64'b10);
    chk("pp_aok", 64'(f_aok), 64'b01);
    nxt();
    f_req = 2'b00;
    #1;
    chk("pp_drain1", 64'(f_dok), 64'b01);
    chk("pp_busy", 64'(f_busy), 64'd1);
    nxt();
    #1;
    chk("pp_drain2", 64'(f_dok), 64'b01);
    nxt();
    f_sdok = 1'b0;
    #1;
    chk("pp_empty", 64'(f_busy), 64'd0);

    // full: four accepted with no response blocks the fifth
    f_req = 2'b10;
    #1;
    chk("fu_acc1", 64'(f_aok), 64'b10);
    nxt();
    f_req = 2'b01;
    #1;
    chk("fu_acc2", 64'(f_aok), 64'b01);
    nxt();
    #1;
    chk("fu_acc3", 64'(f_aok), 64'b01);
    nxt();
    #1;
    chk("fu_acc4", 64'(f_aok), 64'b01);
    nxt();
    #1;
    chk("fu_sreq_blk", 64'(f_sreq), 64'd0);
    chk("fu_aok_blk", 64'(f_aok), 64'd0);
    nxt();
    f_sdok = 1'b1;
    #1;
    chk("fu_head", 64'(f_dok), 64'b10);
    chk("fu_sreq_pop", 64'(f_sreq), 64'd0);
    nxt();
    f_sdok = 1'b0;
    #1;
    chk("fu_sreq_rise", 64'(f_sreq), 64'd1);
    chk("fu_aok_rise", 64'(f_aok), 64'b01);
    nxt();
    f_req = 2'b00; f_sdok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fu_drain", 64'(f_dok), 64'b01);
      nxt();
    end
    f_sdok = 1'b0;
    #1;
    chk("fu_empty", 64'(f_busy), 64'd0);

    // response with empty FIFO: dropped, sticky error until reset
    f_sdok = 1'b1;
    #1;
    chk("pe_dok", 64'(f_dok), 64'd0);
    nxt();
    f_sdok = 1'b0;
    #1;
    chk("pe_set", 64'(f_perr), 64'd1);
    nxt();
    #1;
    chk("pe_held", 64'(f_perr), 64'd1);
    reset = 1'b1; f_req = 2'b11;
    #1;
    chk("pe_rst_sreq", 64'(f_sreq), 64'd0);
    nxt();
    reset = 1'b0; f_req = 2'b00;
    #1;
    chk("pe_clr", 64'(f_perr), 64'd0);
    chk("pe_busy", 64'(f_busy), 64'd0);
    chk("pe_sreq", 64'(f_sreq), 64'd0);
    nxt();

    // round-robin: 0,1,2,0,1,2 with one response per cycle trailing by one
    r_req = 3'b111; r_saok = 1'b1; r_sdok = 1'b0;
    #1;
    chk("rr_acc0", 64'(r_aok), 64'(rr_exp[0]));
    chk("rr_dok0", 64'(r_dok), 64'd0);
    chk("rr_saddr0", 64'(r_saddr), 64'h100);
    nxt();
    r_sdok = 1'b1;
    for (int k = 1; k < 6; k++) begin
      #1;
      chk("rr_acc", 64'(r_aok), 64'(rr_exp[k]));
      chk("rr_dok", 64'(r_dok), 64'(rr_exp[k-1]));
      nxt();
    end
    r_req = 3'b000;
    #1;
    chk("rr_dok_last", 64'(r_dok), 64'b100);
    nxt();
    r_sdok = 1'b0;
    #1;
    chk("rr_empty", 64'(r_busy), 64'd0);
    chk("rr_perr", 64'(r_perr), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Arbitrates NUM_PORTS sram-like masters (IFU fetch, EXEU load/store, later TLB/cache-refill ports) onto a single sram-like memory port.
- It is the successor of the fixed inst/data dual-SRAM split in the CPU top.
- Supports fixed-priority or round-robin grant and up to MAX_OUTSTANDING in-flight requests.
- Read data and data_ok are returned in order to the issuing master, using an ID FIFO.

Parameters:
NUM_PORTS, 2, number of master ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO (power of 2, >=1)
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_req  in  NUM_PORTS  per-port request valid
m_wr  in  NUM_PORTS  per-port 1=write
m_size  in  2*NUM_PORTS  per-port size (0=byte,1=half,2=word)
m_wstrb  in  NUM_PORTS*DATA_W/8  per-port byte strobes
m_addr  in  NUM_PORTS*ADDR_W  per-port address
m_wdata  in  NUM_PORTS*DATA_W  per-port write data
m_addr_ok  out  NUM_PORTS  per-port request accepted
m_data_ok  out  NUM_PORTS  per-port response done
m_rdata  out  DATA_W  read data, broadcast to all ports
s_req  out  1  memory request
s_wr  out  1  memory write
s_size  out  2  memory size
s_wstrb  out  DATA_W/8  memory strobes
s_addr  out  ADDR_W  memory address
s_wdata  out  DATA_W  memory write data
s_addr_ok  in  1  memory accepted request
s_data_ok  in  1  memory response
s_rdata  in  DATA_W  memory read data
busy  out  1  FIFO non-empty
proto_err  out  1  sticky: s_data_ok received with FIFO empty

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty; lock=0; rr_ptr=0; proto_err=0.
  - While reset is high: s_req=0, all m_addr_ok=0, all m_data_ok=0.
- Handshake:
  - sram-like: a request transfers when s_req & s_addr_ok in the same cycle.
  - A master holds m_req and its payload stable until its m_addr_ok.
- Grant:
  - Computed combinationally from m_req when lock=0.
  - Fixed priority: lowest asserted index.
  - Round-robin: first asserted index at or after rr_ptr, searching cyclically.
- Lock:
  - If s_req=1 and s_addr_ok=0, lock=1 and the granted index is registered.
  - While lock=1 the grant is the locked index regardless of other requests or priority.
  - Lock is released in the cycle s_addr_ok arrives.
- Round-robin pointer: on each accepted request, rr_ptr <= granted index + 1 (mod NUM_PORTS). In fixed-priority mode rr_ptr is unused.
- Memory-side outputs:
  - s_req = (any m_req or lock) & !fifo_full.
  - s_wr, s_size, s_wstrb, s_addr and s_wdata are muxed from the granted port. They are zero when s_req=0.
- m_addr_ok[g] = s_req & s_addr_ok for the granted port g only. Zero-cycle latency from s_addr_ok.
- ID FIFO:
  - Each accepted request pushes the granted index.
  - Each s_data_ok pops the head.
  - m_data_ok[head] = s_data_ok & !empty.
  - m_rdata = s_rdata (combinational pass-through).
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - Full (count==MAX_OUTSTANDING): s_req forced 0 and no push. This holds even if a pop occurs that cycle; the new grant waits one cycle.
  - Pointers wrap modulo MAX_OUTSTANDING.
- s_data_ok with an empty FIFO: ignored (no m_data_ok), and proto_err is set until reset.
- Responses are strictly in acceptance order. The memory slave guarantees in-order data_ok.
- busy = !empty.
- Reset mid-transaction: FIFO and lock are cleared. Responses still in flight at the slave are the system's responsibility; the whole core resets together.

Test Plan:
- RR_MODE=0, m_req=2'b11, s_addr_ok=1 every cycle, s_data_ok 1 cycle later → port 0 accepted every cycle, port 1 starves; m_data_ok[0] pulses with s_rdata=0x1C000000 echoed on m_rdata.
- RR_MODE=1, NUM_PORTS=3, m_req=3'b111 constant → accept order 0,1,2,0,1,2; rr_ptr wraps to 0 after port 2.
- Lock: port 1 requests alone with s_addr_ok=0 for 3 cycles, port 0 raises m_req in cycle 2 → s_addr stays port 1's address (e.g. 0x00001000) until s_addr_ok; port 0 is granted the next cycle.
- Full: MAX_OUTSTANDING=4, 4 accepted with no s_data_ok → s_req=0 in cycle 5 despite m_req; one s_data_ok → s_req rises the following cycle; the head ID is returned first.
- Simultaneous push/pop at count=2 → count stays 2; the popped ID matches the oldest accepted port.
- s_data_ok with FIFO empty → no m_data_ok bit, proto_err=1 and held; reset high for 1 cycle → proto_err=0, busy=0, s_req=0.
